// File: rtl/spike_aer_encoder.sv
// Serialises one-cycle neuron spike pulses into {tick_count, neuron_addr} AER packets
// and queues them in a small FIFO toward the router; unsent spikes are dropped at each tick.
module spike_aer_encoder #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4,
  parameter int TICK_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int DROP_W      = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1,
  localparam int PKT_W      = TICK_W + ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   tick,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic                   pkt_ready,
  output logic                   pkt_valid,
  output logic [PKT_W-1:0]       pkt_data,
  output logic [CNT_W-1:0]       fifo_count,
  output logic [DROP_W-1:0]      dropped_cnt,
  output logic                   busy,
  output logic                   dbg_state
);

  // Handshake: a packet moves when pkt_valid & pkt_ready on a rising edge; while
  // pkt_valid is high and pkt_ready low, pkt_valid and pkt_data hold unchanged.

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [NUM_NEURONS-1:0]   pending_q, pending_d, push_mask, held;
  logic [TICK_W-1:0]        tick_count;
  logic [PKT_W-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [ADDR_W-1:0]        sel_idx;
  logic                     sel_found, full, push, pop;
  logic [31:0]              drop_sum;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = ADDR_W'(i);
      end
    end
  end

  // Full is judged on the registered count, so a pop in the same cycle never frees a slot for a push.
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push      = (state_q == DRAIN) && sel_found && !full;
  assign pop       = pkt_valid && pkt_ready;
  assign push_mask = push ? (NUM_NEURONS'(1) << sel_idx) : '0;
  assign held      = pending_q & ~push_mask;
  // New spikes are OR-ed in last so a same-cycle re-spike survives the clear.
  assign pending_d = (tick ? '0 : held) | (enable ? spike_in : '0);
  assign drop_sum  = 32'(dropped_cnt) + 32'($countones(held));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_d != '0) state_d = DRAIN;
      DRAIN:   if (pending_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      tick_count  <= '0;
      dropped_cnt <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (tick) begin
        tick_count <= tick_count + 1'b1;
        if (drop_sum[31:DROP_W] != '0) dropped_cnt <= '1;
        else                           dropped_cnt <= drop_sum[DROP_W-1:0];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tick_count, sel_idx};
  end

  assign pkt_valid = (fifo_count != '0);
  assign pkt_data  = pkt_valid ? mem[rd_ptr] : '0;
  assign busy      = (pending_q != '0) || pkt_valid;
  assign dbg_state = (state_q == DRAIN);

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of pending spikes, FIFO contents and drop count.
module tb_spike_aer_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        tick;
  logic [15:0] spike_in;
  logic        pkt_ready;
  logic        pkt_valid;
  logic [11:0] pkt_data;
  logic [3:0]  fifo_count;
  logic [7:0]  dropped_cnt;
  logic        busy;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [11:0] exp_q[$];
  bit   [15:0] m_pend;
  bit   [7:0]  m_tc;
  int          m_drop;

  spike_aer_encoder dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick), .spike_in(spike_in),
    .pkt_ready(pkt_ready), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .fifo_count(fifo_count), .dropped_cnt(dropped_cnt), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pend = '0;
    m_tc   = '0;
    m_drop = 0;
  endtask

  // One clock edge of the behavioural rules, using the pre-edge model state.
  task automatic model_step(input bit e, input bit t, input bit [15:0] s, input bit r);
    bit do_pop, do_push;
    do_pop  = (exp_q.size() != 0) && r;
    do_push = (m_pend != 0) && (exp_q.size() < 8);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      for (int k = 0; k < 16; k++) begin
        if (m_pend[k]) begin
          exp_q.push_back({m_tc, 4'(k)});
          m_pend[k] = 1'b0;
          break;
        end
      end
    end
    if (t) begin
      m_drop = m_drop + $countones(m_pend);
      if (m_drop > 255) m_drop = 255;
      m_pend = '0;
      m_tc   = m_tc + 8'd1;
    end
    if (e) m_pend = m_pend | s;
  endtask

  task automatic check_all();
    check("pkt_valid",   32'(pkt_valid),   32'(exp_q.size() != 0));
    check("pkt_data",    32'(pkt_data),    (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check("fifo_count",  32'(fifo_count),  32'(exp_q.size()));
    check("dropped_cnt", 32'(dropped_cnt), 32'(m_drop));
    check("busy",        32'(busy),        32'((m_pend != 0) || (exp_q.size() != 0)));
  endtask

  // Driver: apply inputs for one cycle, advance model at the edge, check 1 time unit later.
  task automatic cyc(input bit e, input bit t, input bit [15:0] s, input bit r);
    enable = e; tick = t; spike_in = s; pkt_ready = r;
    @(posedge clk);
    model_step(e, t, s, r);
    #1 check_all();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, r);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tick = 1'b0; spike_in = '0; pkt_ready = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Single spike on neuron 0: valid two cycles later with data 12'h000
    cyc(1, 0, 16'h0001, 1);
    check("lat_c1_valid", 32'(pkt_valid), 32'd0);
    cyc(1, 0, 16'h0000, 1);
    check("lat_c2_valid", 32'(pkt_valid), 32'd1);
    check("lat_c2_data",  32'(pkt_data),  32'h000);
    idle(3, 1);
    check("lat_busy_idle", 32'(busy), 32'd0);

    // Four simultaneous spikes, ascending order, same stamp
    cyc(1, 0, 16'h8421, 1);
    idle(7, 1);

    // FIFO fills with ready low, tick drops the remainder, then drain
    cyc(1, 0, 16'hFFFF, 0);
    idle(10, 0);
    check("full_count", 32'(fifo_count), 32'd8);
    cyc(1, 1, 16'h0000, 0);
    check("full_drop8", 32'(dropped_cnt), 32'd8);
    idle(3, 0);
    idle(10, 1);

    // Re-spike on bit 3 in the cycle it is pushed
    cyc(1, 0, 16'h0008, 1);
    cyc(1, 0, 16'h0008, 1);
    idle(5, 1);

    // Tick counter wrap: FF stamp, then tick+spike stamped 00
    while (m_tc != 8'hFF) cyc(1, 1, 16'h0000, 1);
    cyc(1, 0, 16'h0002, 1);
    cyc(1, 1, 16'h0010, 1);
    idle(4, 1);

    // Disabled capture
    cyc(0, 0, 16'hFFFF, 1);
    cyc(0, 0, 16'hFFFF, 1);
    check("dis_busy", 32'(busy), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 16'hFFFF, 0);
      cyc(1, 1, 16'h0000, 0);
    end
    check("drop_sat", 32'(dropped_cnt), 32'hFF);
    idle(12, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(bit'($urandom_range(0, 7) != 0), bit'($urandom_range(0, 9) == 0),
          16'($urandom) & 16'($urandom) & 16'($urandom), bit'($urandom_range(0, 3) != 0));
    end
    idle(30, 1);

    // Reset mid-drain with 3 packets queued
    cyc(1, 0, 16'h0007, 0);
    idle(4, 0);
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", 32'(pkt_valid),  32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_data",  32'(pkt_data),   32'd0);
    @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    idle(2, 1);
    check("rst_drop", 32'(dropped_cnt), 32'd0);
    cyc(1, 0, 16'h0100, 1);
    idle(4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
